serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/bit_full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bit_full_adder.sv
// One-bit full adder cell; the single datapath element time-shared by serial_adder_ctrl.
module bit_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, start/busy/done handshake.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             cell_s, cell_c;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as A + ~B + 1; cout then reads as "no borrow".
    assign b_load = sub ? ~inB : inB;
    assign c_load = sub | cin;
`else
    assign b_load = inB;
    assign c_load = cin;
`endif

    bit_full_adder u_cell (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (cell_s),
        .c_o (cell_c)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = inA;
                    b_d     = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {cell_s, res_q[WIDTH-1:1]};
                carry_d = cell_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = {cell_s, res_q[WIDTH-1:1]};
                    cout_d  = cell_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all datapath registers are reset too, so an abandoned operation leaves no stale bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random operations against an arithmetic model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] inA, inB;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .inA   (inA),
        .inB   (inB),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: the whole operation is just a wide addition (or A + ~B + 1 when subtracting).
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        logic [W-1:0] nb;
        nb = ~b;
        if (s) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input logic st);
        inA   = a;
        inB   = b;
        cin   = c;
        start = st;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = s;
`endif
    endtask

    // Called just after the accepting edge; returns edges until done is seen, -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 3 * W; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s);
        logic [W:0] e;
        int         lat;
        e = model(a, b, c, s);
        @(negedge clk);
        drive(a, b, c, s, 1'b1);
        @(posedge clk); #1;
        drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        check({tag, " busy_rise"}, busy, 1);
        wait_done(lat);
        check({tag, " latency"}, lat, W);
        check({tag, " sum"}, sum, e[W-1:0]);
        check({tag, " cout"}, cout, e[W]);
        check({tag, " busy_in_done"}, busy, 1);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " busy_fall"}, busy, 0);
    endtask

    initial begin
        logic [W:0]   e, e2;
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           lat, ndone;
        logic         busy_ok;

        rst_n = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        #12;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic", 8'h3C, 8'h5A, 1'b0, 1'b0);
        run_op("wrap1", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op("wrap2", 8'hFF, 8'hFF, 1'b1, 1'b0);

        // start pulses mid-RUN and in the DONE cycle must be ignored
        e = model(8'hA5, 8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        drive(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = -1;
        ndone   = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            if (k == 4 || k == W + 1) drive(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (busy !== (k <= W)) busy_ok = 1'b0;
        end
        check("ign latency", lat, W);
        check("ign done_count", ndone, 1);
        check("ign busy_profile", busy_ok, 1);
        check("ign sum", sum, e[W-1:0]);
        check("ign cout", cout, e[W]);

        // start held high re-triggers on the first IDLE edge
        e  = model(8'h81, 8'h7F, 1'b0, 1'b0);
        e2 = model(8'h4D, 8'h9E, 1'b1, 1'b0);
        @(negedge clk);
        drive(8'h81, 8'h7F, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        wait_done(lat);
        check("held latency1", lat, W);
        check("held sum1", sum, e[W-1:0]);
        check("held cout1", cout, e[W]);
        @(negedge clk);
        drive(8'h4D, 8'h9E, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("held idle_gap", busy, 0);
        @(posedge clk); #1;
        check("held retrigger", busy, 1);
        start = 1'b0;
        wait_done(lat);
        check("held latency2", lat, W);
        check("held sum2", sum, e2[W-1:0]);
        check("held cout2", cout, e2[W]);
        @(posedge clk); #1;

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        drive(8'hC3, 8'h0F, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst busy", busy, 0);
        check("arst done", done, 0);
        check("arst sum", sum, 0);
        check("arst cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (2 * W) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("arst no_done", ndone, 0);
        run_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0);

        // outputs hold while inputs wiggle without start
        e = model(8'h01, 8'h01, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
            @(posedge clk); #1;
            check("hold sum", sum, e[W-1:0]);
            check("hold cout", cout, e[W]);
            check("hold busy", busy, 0);
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_neg", 8'h05, 8'h07, 1'b0, 1'b1);
        run_op("sub_pos", 8'h07, 8'h05, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op("random", ra, rb, rc, rs);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
